// File: rtl/alu_pkg.sv
// Shared opcodes, compare result codes and divider state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR = 4'h7;
  localparam logic [3:0] OP_NOP = 4'h8;
  localparam logic [3:0] OP_EQ  = 4'h9;
  localparam logic [3:0] OP_GT  = 4'hA;
  localparam logic [3:0] OP_LT  = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SRA = 4'hE;
  localparam logic [3:0] OP_ROL = 4'hF;

  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;
  localparam int CMP_LT = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic dz;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring signed divider: one quotient bit per cycle on magnitudes, signs applied at the end.
//   state  | meaning
//   S_IDLE | waiting for start_i
//   S_DIV  | WIDTH restoring iterations, cnt_q counts down to terminal 0
//   S_FIX  | signed quotient/remainder presented, done_o high for one cycle
module alu_seq_div
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [WIDTH-1:0]        quo_o,
  output logic [WIDTH-1:0]        rem_o,
  output logic                    ovf_o
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    a_mag = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
    b_mag = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_DIV;
          cnt_d     = CW'(WIDTH - 1);
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          neg_quo_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          neg_rem_d = a_i[WIDTH-1];
          ovf_d     = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
        end
      end
      S_DIV: begin
        // no borrow means the shifted remainder covers the divisor
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - CW'(1);
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIX);
  assign quo_o  = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign rem_o  = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle signed ALU: operand register on accept, single-cycle datapath or iterative
// divider, then one registered 2*WIDTH result with flags and a one-cycle OUT_VALID pulse.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic [3:0]              ALU_FUN,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [2*WIDTH-1:0]      ALU_OUT,
  output logic                    OUT_VALID,
  output logic                    Carry_OUT,
  output logic                    OVF,
  output logic                    DIV_ZERO
);

  localparam int SHW = $clog2(WIDTH);
  localparam int DW  = 2 * WIDTH;

  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]              fun_q, fun_d;
  logic                    vld_q, vld_d;
  logic                    pend_q, pend_d;
  logic [DW-1:0]           alu_out_q, alu_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

  logic                    accept, div_start, div_busy, div_done, div_ovf;
  logic [WIDTH-1:0]        div_quo, div_rem;
  logic [SHW-1:0]          sh;
  logic signed [WIDTH:0]   sum_x, dif_x;
  logic signed [DW-1:0]    a_x, b_x, prod;
  logic [DW-1:0]           rot_x, res;
  alu_flags_t              flg;

  // Ready drops on the divide accept edge and stays low until the result cycle
  assign IN_READY  = ~(pend_q | div_busy);
  assign accept    = IN_VALID & IN_READY;
  assign div_start = vld_q && (fun_q == OP_DIV) && (b_q != '0);

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    fun_d  = fun_q;
    vld_d  = accept;
    pend_d = pend_q;
    if (accept) begin
      a_d   = A;
      b_d   = B;
      fun_d = ALU_FUN;
    end
    if (accept && (ALU_FUN == OP_DIV) && (B != '0)) pend_d = 1'b1;
    else if (div_start) pend_d = 1'b0;
  end

  always_comb begin
    sh    = b_q[SHW-1:0];
    sum_x = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    dif_x = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    a_x   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_x   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = a_x * b_x;
    rot_x = {a_q, a_q} << sh;
    res   = '0;
    flg   = '0;
    case (fun_q)
      OP_ADD: begin
        res       = {{(WIDTH-1){sum_x[WIDTH]}}, sum_x};
        flg.carry = sum_x[WIDTH];
        flg.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_x[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res       = {{(WIDTH-1){dif_x[WIDTH]}}, dif_x};
        flg.carry = dif_x[WIDTH];
        flg.ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_x[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL:  res = prod;
      OP_DIV:  flg.dz = (b_q == '0);
      OP_AND:  res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_NAND: res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OP_NOR:  res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OP_EQ:   res = (a_q == b_q) ? DW'(CMP_EQ) : '0;
      OP_GT:   res = (a_q > b_q) ? DW'(CMP_GT) : '0;
      OP_LT:   res = (a_q < b_q) ? DW'(CMP_LT) : '0;
      OP_SHR:  res = {{WIDTH{1'b0}}, a_q >> sh};
      OP_SHL:  res = {{WIDTH{1'b0}}, a_q << sh};
      OP_SRA:  res = {{WIDTH{1'b0}}, a_q >>> sh};
      OP_ROL:  res = {{WIDTH{1'b0}}, rot_x[DW-1:WIDTH]};
      default: res = '0;
    endcase
  end

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk     (CLK),
    .rst     (RST),
    .start_i (div_start),
    .a_i     (a_q),
    .b_i     (b_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo),
    .rem_o   (div_rem),
    .ovf_o   (div_ovf)
  );

  always_comb begin
    alu_out_d   = alu_out_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = 1'b0;
    if (div_done) begin
      alu_out_d   = {div_rem, div_quo};
      carry_d     = 1'b0;
      ovf_d       = div_ovf;
      dz_d        = 1'b0;
      out_valid_d = 1'b1;
    end else if (vld_q && !div_start) begin
      alu_out_d   = res;
      carry_d     = flg.carry;
      ovf_d       = flg.ovf;
      dz_d        = flg.dz;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      vld_q       <= 1'b0;
      pend_q      <= 1'b0;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      vld_q       <= vld_d;
      pend_q      <= pend_d;
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign ALU_OUT   = alu_out_q;
  assign OUT_VALID = out_valid_q;
  assign Carry_OUT = carry_q;
  assign OVF       = ovf_q;
  assign DIV_ZERO  = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): directed vector table, handshake corner sequences,
// and randomized operations compared against an integer-arithmetic reference model.
module tb_alu_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] A, B;
  logic [3:0]  ALU_FUN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] ALU_OUT;
  logic        OUT_VALID, Carry_OUT, OVF, DIV_ZERO;

  int checks = 0;
  int failures = 0;

  alu_mc #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .Carry_OUT (Carry_OUT),
    .OVF       (OVF),
    .DIV_ZERO  (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
    int          lat;
    int          rlow;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] r, input logic c, input logic o, input logic z,
                      input int lat, input int rlow);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.r = r; v.c = c; v.o = o; v.z = z; v.lat = lat; v.rlow = rlow;
    tv.push_back(v);
  endtask

  // Reference: plain signed integer arithmetic on the operand values
  function automatic void model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] r, output logic c, output logic o,
                                output logic z);
    int sa, sb, s, q, m, sh;
    logic [31:0] ua;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    ua = {16'h0, a};
    r = '0; c = 1'b0; o = 1'b0; z = 1'b0;
    case (f)
      4'h0: begin s = sa + sb; r = s; c = (s < 0); o = (s > 32767) || (s < -32768); end
      4'h1: begin s = sa - sb; r = s; c = (s < 0); o = (s > 32767) || (s < -32768); end
      4'h2: r = sa * sb;
      4'h3: begin
        if (sb == 0) z = 1'b1;
        else begin
          q = sa / sb;
          m = sa % sb;
          o = (q > 32767);
          r = {16'(m), 16'(q)};
        end
      end
      4'h4: r = {16'h0, a & b};
      4'h5: r = {16'h0, a | b};
      4'h6: r = {16'h0, ~(a & b)};
      4'h7: r = {16'h0, ~(a | b)};
      4'h9: r = (sa == sb) ? 32'd1 : 32'd0;
      4'hA: r = (sa > sb) ? 32'd2 : 32'd0;
      4'hB: r = (sa < sb) ? 32'd3 : 32'd0;
      4'hC: r = ua >> sh;
      4'hD: r = (ua << sh) & 32'h0000FFFF;
      4'hE: begin s = sa >>> sh; r = s & 32'h0000FFFF; end
      4'hF: r = ((ua << sh) | (ua >> (16 - sh))) & 32'h0000FFFF;
      default: r = '0;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge on which OUT_VALID is seen
  task automatic do_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] r, output logic [2:0] flags, output int lat,
                       output int rlow, output logic rdy_ov);
    int guard;
    guard = 0;
    lat = 0; rlow = 0; rdy_ov = 1'b0; r = '0; flags = '0;
    while (!IN_READY && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got IN_READY=0 want 1 within 100 cycles");
    end
    IN_VALID = 1'b1; ALU_FUN = f; A = a; B = b;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    if (!IN_READY) rlow++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) begin
        lat = i;
        rdy_ov = IN_READY;
        r = ALU_OUT;
        flags = {Carry_OUT, OVF, DIV_ZERO};
        break;
      end
      if (!IN_READY) rlow++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er, r1, r2;
    logic [2:0]  fl;
    logic        ec, eo, ez, rov;
    int          lat, rlow, p1, p2, np, seen;
    logic [3:0]  rf[64];
    logic [15:0] ra[64], rb[64];
    logic [31:0] rr[64];
    logic [2:0]  rfl[64];
    logic [15:0] da, db;

    RST = 1'b1; IN_VALID = 1'b0; ALU_FUN = 4'h0; A = '0; B = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset_out", ALU_OUT, 32'h0);
    chk("reset_valid", OUT_VALID, 1'b0);
    chk("reset_ready", IN_READY, 1'b1);
    chk("reset_flags", {Carry_OUT, OVF, DIV_ZERO}, 3'b000);

    addv(4'h0, 16'hEA20, 16'hD120, 32'hFFFFBB40, 1, 0, 0, 1, 0);
    addv(4'h0, 16'h1C20, 16'h01A4, 32'h00001DC4, 0, 0, 0, 1, 0);
    addv(4'h1, 16'hEA20, 16'h01A4, 32'hFFFFE87C, 1, 0, 0, 1, 0);
    addv(4'h0, 16'h7FFF, 16'h0001, 32'h00008000, 0, 1, 0, 1, 0);
    addv(4'h2, 16'h1C20, 16'hD120, 32'hFAD9A400, 0, 0, 0, 1, 0);
    addv(4'h1, 16'h8000, 16'h0001, 32'hFFFF7FFF, 1, 1, 0, 1, 0);
    addv(4'h2, 16'hEA20, 16'hD120, 32'h04016400, 0, 0, 0, 1, 0);
    addv(4'hA, 16'h61A8, 16'h1388, 32'h00000002, 0, 0, 0, 1, 0);
    addv(4'h9, 16'h61A8, 16'h1388, 32'h00000000, 0, 0, 0, 1, 0);
    addv(4'h9, 16'h1388, 16'h1388, 32'h00000001, 0, 0, 0, 1, 0);
    addv(4'hB, 16'h1388, 16'h61A8, 32'h00000003, 0, 0, 0, 1, 0);
    addv(4'hA, 16'h8000, 16'h0001, 32'h00000000, 0, 0, 0, 1, 0);
    addv(4'hC, 16'h61A8, 16'h0001, 32'h000030D4, 0, 0, 0, 1, 0);
    addv(4'hD, 16'h61A8, 16'h0001, 32'h0000C350, 0, 0, 0, 1, 0);
    addv(4'hE, 16'h8000, 16'h0003, 32'h0000F000, 0, 0, 0, 1, 0);
    addv(4'hF, 16'h8000, 16'h0003, 32'h00000004, 0, 0, 0, 1, 0);
    addv(4'hC, 16'h8000, 16'h0003, 32'h00001000, 0, 0, 0, 1, 0);
    addv(4'h8, 16'h1234, 16'h5678, 32'h00000000, 0, 0, 0, 1, 0);
    addv(4'h3, 16'hEA20, 16'h01A4, 32'hFF74FFF3, 0, 0, 0, 18, 18);
    addv(4'h3, 16'h1C20, 16'h01A4, 32'h003C0011, 0, 0, 0, 18, 18);
    addv(4'h3, 16'h0064, 16'h0000, 32'h00000000, 0, 0, 1, 1, 0);
    addv(4'h3, 16'h8000, 16'hFFFF, 32'h00008000, 0, 1, 0, 18, 18);

    foreach (tv[i]) begin
      do_op(tv[i].f, tv[i].a, tv[i].b, r, fl, lat, rlow, rov);
      chk($sformatf("vec%0d_res", i), r, tv[i].r);
      chk($sformatf("vec%0d_flags", i), fl, {tv[i].c, tv[i].o, tv[i].z});
      chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d_ready_low", i), rlow, tv[i].rlow);
      chk($sformatf("vec%0d_ready_at_valid", i), rov, 1'b1);
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("hold_out", ALU_OUT, tv[tv.size()-1].r);
    chk("hold_valid", OUT_VALID, 1'b0);

    // Random single-cycle ops, one accept per cycle
    for (int i = 0; i < 64; i++) begin
      rf[i] = 4'($urandom_range(0, 15));
      if (rf[i] == 4'h3) rf[i] = 4'h0;
      ra[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      rb[i] = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      model(rf[i], ra[i], rb[i], er, ec, eo, ez);
      rr[i] = er;
      rfl[i] = {ec, eo, ez};
    end
    IN_VALID = 1'b1; ALU_FUN = rf[0]; A = ra[0]; B = rb[0];
    for (int i = 0; i <= 64; i++) begin
      @(posedge CLK); #1;
      if (i >= 1)
        chk($sformatf("b2b%0d_f%0h", i - 1, rf[i-1]),
            {OUT_VALID, IN_READY, ALU_OUT, Carry_OUT, OVF, DIV_ZERO},
            {1'b1, 1'b1, rr[i-1], rfl[i-1]});
      if (i < 63) begin
        ALU_FUN = rf[i+1]; A = ra[i+1]; B = rb[i+1];
      end else IN_VALID = 1'b0;
    end

    // Random divides including zero divisor and MIN/-1
    for (int i = 0; i < 24; i++) begin
      da = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 4))
        0: db = 16'h0000;
        1: db = 16'hFFFF;
        2: db = 16'($urandom_range(1, 20));
        default: db = 16'($urandom);
      endcase
      model(4'h3, da, db, er, ec, eo, ez);
      do_op(4'h3, da, db, r, fl, lat, rlow, rov);
      chk($sformatf("rdiv%0d_res_%h_%h", i, da, db), r, er);
      chk($sformatf("rdiv%0d_flags", i), fl, {ec, eo, ez});
      chk($sformatf("rdiv%0d_latency", i), lat, (db == 16'h0) ? 1 : 18);
    end

    // Add offered while the divider is busy must wait for the divide result cycle
    IN_VALID = 1'b1; ALU_FUN = 4'h3; A = 16'h1C20; B = 16'h01A4;
    @(posedge CLK); #1;
    ALU_FUN = 4'h0; A = 16'h0001; B = 16'h0002;
    p1 = -1; p2 = -1; np = 0; r1 = '0; r2 = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK); #1;
      if (i == 19) IN_VALID = 1'b0;
      if (OUT_VALID) begin
        np++;
        if (np == 1) begin p1 = i; r1 = ALU_OUT; end
        else if (np == 2) begin p2 = i; r2 = ALU_OUT; end
      end
    end
    IN_VALID = 1'b0;
    chk("busy_pulses", np, 2);
    chk("busy_div_at", p1, 18);
    chk("busy_div_res", r1, 32'h003C0011);
    chk("busy_add_at", p2, 20);
    chk("busy_add_res", r2, 32'h00000003);

    // Reset during divide iterations
    IN_VALID = 1'b1; ALU_FUN = 4'h3; A = 16'hEA20; B = 16'h01A4;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_valid", OUT_VALID, 1'b0);
    chk("abort_out", ALU_OUT, 32'h0);
    chk("abort_ready", IN_READY, 1'b1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen++;
    end
    chk("abort_no_pulse", seen, 0);
    do_op(4'h0, 16'h1C20, 16'h01A4, r, fl, lat, rlow, rov);
    chk("abort_next_add", r, 32'h00001DC4);
    chk("abort_next_lat", lat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
